// File: rtl/priority_arbiter.sv
// Single-owner arbiter with hold timeout and registered one-hot grant.
// PRIORITY_ARBITER_RR_EN: round-robin when defined, fixed priority otherwise.
module priority_arbiter #(
  parameter int n        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [n-1:0]         req,
  output logic [n-1:0]         gnt,
  output logic [$clog2(n)-1:0] gnt_id,
  output logic                 v,
  output logic                 expired
);

  localparam int IW = $clog2(n);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] hold_cnt, hold_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [IW-1:0] id_nx, win_id;
  logic [n-1:0]  gnt_nx, cand;
  logic          win, rel, exp_nx;

  // owner bit is never a candidate; gnt is zero in IDLE
  assign cand = req & ~gnt;

`ifdef PRIORITY_ARBITER_RR_EN
  always_comb begin
    int k;
    k      = 0;
    win    = 1'b0;
    win_id = '0;
    for (int i = 1; i <= n; i++) begin
      k = (int'(ptr) + i) % n;
      if (!win && cand[k]) begin
        win    = 1'b1;
        win_id = IW'(k);
      end
    end
  end
`else
  always_comb begin
    win    = 1'b0;
    win_id = '0;
    for (int k = 0; k < n; k++) begin
      if (cand[k]) begin
        win    = 1'b1;
        win_id = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    id_nx    = gnt_id;
    hold_nx  = hold_cnt;
    ptr_nx   = ptr;
    exp_nx   = 1'b0;
    rel      = 1'b0;
    unique case (state)
      IDLE: rel = 1'b1;
      GRANT: begin
        if (!req[gnt_id]) begin
          rel = 1'b1;
        end else if (hold_cnt == CW'(MAX_HOLD)) begin
          rel    = 1'b1;
          exp_nx = 1'b1;
        end else begin
          hold_nx = hold_cnt + CW'(1);
        end
      end
      default: ;
    endcase
    if (rel) begin
      if (win) begin
        state_nx       = GRANT;
        gnt_nx         = '0;
        gnt_nx[win_id] = 1'b1;
        id_nx          = win_id;
        hold_nx        = CW'(1);
        ptr_nx         = win_id;
      end else begin
        state_nx = IDLE;
        gnt_nx   = '0;
        id_nx    = '0;
        hold_nx  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      v        <= 1'b0;
      expired  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= IW'(n - 1);
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      gnt_id   <= id_nx;
      v        <= |gnt_nx;
      expired  <= exp_nx;
      hold_cnt <= hold_nx;
      ptr      <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: ownership model plus directed scenarios.
// Follows PRIORITY_ARBITER_RR_EN for the expected policy.
module tb_priority_arbiter;

  localparam int N   = 4;
  localparam int MH  = 8;
  localparam int N5  = 5;
  localparam int MH5 = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         v, expired;

  logic [N5-1:0] req5 = '0;
  logic [N5-1:0] gnt5;
  logic [2:0]    gnt_id5;
  logic          v5, expired5;

  int checks = 0;
  int fails  = 0;
  bit checking = 1'b0;

  int           m_owner = -1;
  int           m_held  = 0;
  int           m_last  = N - 1;
  bit           m_exp   = 1'b0;
  logic [N-1:0] mreq;

  always #5 clk = ~clk;

  priority_arbiter #(.n(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .v(v), .expired(expired)
  );

  priority_arbiter #(.n(N5), .MAX_HOLD(MH5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5),
    .gnt(gnt5), .gnt_id(gnt_id5), .v(v5), .expired(expired5)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int last);
    int w;
    w = -1;
`ifdef PRIORITY_ARBITER_RR_EN
    for (int i = 1; i <= N; i++)
      if (w < 0 && m[(last + i) % N]) w = (last + i) % N;
`else
    for (int k = 0; k < N; k++)
      if (m[k]) w = k;
`endif
    return w;
  endfunction

  // ownership model: who owns the resource and for how long
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
      m_exp   = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (m_owner >= 0 && req[m_owner] && m_held < MH) begin
        m_held++;
      end else if (m_owner >= 0 || req != '0) begin
        m_exp = (m_owner >= 0) && req[m_owner];
        mreq = req;
        if (m_owner >= 0) mreq[m_owner] = 1'b0;
        m_owner = pick(mreq, m_last);
        m_held  = (m_owner >= 0) ? 1 : 0;
        if (m_owner >= 0) m_last = m_owner;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("m_gnt", 32'(gnt),
          (m_owner >= 0) ? 32'(1) << m_owner : 32'd0);
      chk("m_gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("m_v", 32'(v), 32'(m_owner >= 0));
      chk("m_expired", 32'(expired), 32'(m_exp));
    end
  end

  task automatic cyc(input logic [N-1:0] r, input int k);
    req = r;
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int e0, e1, e5;
`ifdef PRIORITY_ARBITER_RR_EN
    e0 = 0; e1 = 1; e5 = 0;
`else
    e0 = 3; e1 = 2; e5 = 3;
`endif
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_id", 32'(gnt_id), 0);
    chk("rst_v", 32'(v), 0);
    chk("rst_exp", 32'(expired), 0);
    rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    // single requester, normal release
    cyc(4'b0100, 1);
    chk("one_gnt", 32'(gnt), 32'b0100);
    chk("one_id", 32'(gnt_id), 2);
    chk("one_v", 32'(v), 1);
    cyc(4'b0100, 2);
    cyc(4'b0000, 1);
    chk("one_rel_gnt", 32'(gnt), 0);
    chk("one_rel_v", 32'(v), 0);
    chk("one_rel_exp", 32'(expired), 0);

    // handover without idle gap, no preemption
    cyc(4'b0010, 1);
    cyc(4'b1010, 2);
    chk("nopre_gnt", 32'(gnt), 32'b0010);
    cyc(4'b1000, 1);
    chk("hand_gnt", 32'(gnt), 32'b1000);
    chk("hand_exp", 32'(expired), 0);
    cyc(4'b0000, 2);

    // all requesting: timeout rotation
    cyc(4'b1111, 1);
    chk("all_first", 32'(gnt_id), 32'(e0));
    cyc(4'b1111, 8);
    chk("all_second", 32'(gnt_id), 32'(e1));
    chk("all_exp", 32'(expired), 1);
    cyc(4'b1111, 1);
    chk("all_exp_clr", 32'(expired), 0);
    cyc(4'b1111, 24);
    cyc(4'b0000, 2);

    // owner drops on its last allowed cycle
    cyc(4'b0001, 1);
    cyc(4'b0101, 7);
    chk("last_hold", 32'(gnt), 32'b0001);
    cyc(4'b0100, 1);
    chk("last_gnt", 32'(gnt), 32'b0100);
    chk("last_exp", 32'(expired), 0);
    cyc(4'b0000, 2);

    // asynchronous reset during a grant
    cyc(4'b0010, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_v", 32'(v), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0001, 1);
    chk("post_rst", 32'(gnt), 32'b0001);
    cyc(4'b0000, 2);

    // five requesters: owner 4 times out
    req5 = 5'b10000;
    @(negedge clk);
    chk("n5_own4", 32'(gnt5), 32'b10000);
    req5 = 5'b11111;
    repeat (3) @(negedge clk);
    chk("n5_next", 32'(gnt_id5), 32'(e5));
    chk("n5_exp", 32'(expired5), 1);
    req5 = '0;
    repeat (2) @(negedge clk);
    chk("n5_idle", 32'(v5), 0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
